// File: rtl/video_timing_gen.sv
// Raster timing generator for the 1280x720@60Hz CVT-RBv2 HDMI path.
// It runs in the pixel clock domain. It produces a pixel-request stream for the
// frame-buffer/tile renderer. It also produces de/hsync/vsync for the TMDS encoder.
// Those video outputs trail the request stream by PIX_LEAD cycles.
//
// Ports:
//   clk_pix     - pixel clock
//   srst_n      - asynchronous active-low reset
//   run         - enable; low holds the raster idle at the origin
//   pix_req     - pixel fetch request for (pix_x, pix_y)
//   pix_x/pix_y - requested column/row; zero while pix_req is low
//   frame_start - one-cycle pulse with the request for (0,0)
//   de          - data enable, PIX_LEAD cycles after the matching pix_req
//   hsync/vsync - sync outputs, aligned with de
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FRONT  = 8,
  parameter int unsigned H_SYNC   = 32,
  parameter int unsigned H_BACK   = 40,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FRONT  = 7,
  parameter int unsigned V_SYNC   = 8,
  parameter int unsigned V_BACK   = 6,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned PIX_LEAD = 2
) (
  input  logic        clk_pix,
  input  logic        srst_n,
  input  logic        run,
  output logic        pix_req,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic        frame_start,
  output logic        de,
  output logic        hsync,
  output logic        vsync
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 2047) begin : g_bad_htotal
    $error("video_timing_gen: H_TOTAL exceeds the 11-bit counter");
  end
  if (V_TOTAL > 1023) begin : g_bad_vtotal
    $error("video_timing_gen: V_TOTAL exceeds the 10-bit counter");
  end
  if (PIX_LEAD > 7) begin : g_bad_lead
    $error("video_timing_gen: PIX_LEAD must be 0..7");
  end

  localparam logic [10:0] HA       = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [9:0]  VA       = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);

  logic [10:0] hcnt_q;
  logic [9:0]  vcnt_q;

  // Raster counters; run low parks them at the origin.
  always_ff @(posedge clk_pix or negedge srst_n) begin
    if (!srst_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else if (!run) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else if (hcnt_q == H_LAST) begin
      hcnt_q <= '0;
      vcnt_q <= (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
    end else begin
      hcnt_q <= hcnt_q + 11'd1;
    end
  end

  logic active;
  logic hs_lvl;
  logic vs_lvl;

  always_comb begin
    active = (hcnt_q < HA) && (vcnt_q < VA);
    hs_lvl = ((hcnt_q >= HS_START) && (hcnt_q < HS_END)) ? HS_POL : ~HS_POL;
    // vcnt only moves on the line wrap, so vsync edges land on hcnt = 0.
    vs_lvl = ((vcnt_q >= VS_START) && (vcnt_q < VS_END)) ? VS_POL : ~VS_POL;
  end

  // Request stage. The sync levels are registered here too, so the video
  // pipeline starts exactly aligned with pix_req.
  logic hs_req_q;
  logic vs_req_q;

  always_ff @(posedge clk_pix or negedge srst_n) begin
    if (!srst_n) begin
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      hs_req_q    <= ~HS_POL;
      vs_req_q    <= ~VS_POL;
    end else if (!run) begin
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      hs_req_q    <= ~HS_POL;
      vs_req_q    <= ~VS_POL;
    end else begin
      pix_req     <= active;
      pix_x       <= active ? hcnt_q : 11'd0;
      pix_y       <= active ? vcnt_q : 10'd0;
      frame_start <= (hcnt_q == 11'd0) && (vcnt_q == 10'd0);
      hs_req_q    <= hs_lvl;
      vs_req_q    <= vs_lvl;
    end
  end

  // Video delay pipeline. It keeps shifting while run is low, so the outputs
  // drain to idle behind the request stage.
  if (PIX_LEAD == 0) begin : g_no_lead
    assign de    = pix_req;
    assign hsync = hs_req_q;
    assign vsync = vs_req_q;
  end else begin : g_lead
    logic [PIX_LEAD-1:0] de_pipe_q;
    logic [PIX_LEAD-1:0] hs_pipe_q;
    logic [PIX_LEAD-1:0] vs_pipe_q;

    always_ff @(posedge clk_pix or negedge srst_n) begin
      if (!srst_n) begin
        de_pipe_q <= '0;
        hs_pipe_q <= {PIX_LEAD{~HS_POL}};
        vs_pipe_q <= {PIX_LEAD{~VS_POL}};
      end else begin
        de_pipe_q[0] <= pix_req;
        hs_pipe_q[0] <= hs_req_q;
        vs_pipe_q[0] <= vs_req_q;
        for (int i = 1; i < int'(PIX_LEAD); i++) begin
          de_pipe_q[i] <= de_pipe_q[i-1];
          hs_pipe_q[i] <= hs_pipe_q[i-1];
          vs_pipe_q[i] <= vs_pipe_q[i-1];
        end
      end
    end

    assign de    = de_pipe_q[PIX_LEAD-1];
    assign hsync = hs_pipe_q[PIX_LEAD-1];
    assign vsync = vs_pipe_q[PIX_LEAD-1];
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench for video_timing_gen. It has one full-size instance (PIX_LEAD=2).
// It also has four reduced-geometry instances with PIX_LEAD = 0, 1, 2 and 7.
// In the reduced geometry, H_TOTAL = 25 and V_TOTAL = 11.
// The reduced instances allow whole-frame checks within a short run.
module tb_video_timing_gen;

  logic clk_pix = 1'b0;
  logic srst_n  = 1'b0;
  logic run_a   = 1'b0;
  logic run_s   = 1'b0;

  always #5 clk_pix = ~clk_pix;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Independent raster model. It gives the request-stage values for a given
  // raster position:
  //   {req, fs, x[10:0], y[9:0], de, hs, vs}
  // A negative position means idle.
  function automatic logic [25:0] model(input bit big, input int pos);
    int ha, hf, hsw, hb, va, vf, vsw, vb, ht, vt, h, v;
    logic act;
    ha = big ? 1280 : 16; hf = big ? 8 : 2; hsw = big ? 32 : 3; hb = big ? 40 : 4;
    va = big ? 720 : 6;   vf = big ? 7 : 2; vsw = big ? 8 : 2;  vb = big ? 6 : 1;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (pos < 0) return {2'b00, 11'd0, 10'd0, 3'b001};
    h   = pos % ht;
    v   = (pos / ht) % vt;
    act = (h < ha) && (v < va);
    return {act, (h == 0) && (v == 0), act ? 11'(h) : 11'd0, act ? 10'(v) : 10'd0,
            act, (h >= ha + hf) && (h < ha + hf + hsw),
            !((v >= va + vf) && (v < va + vf + vsw))};
  endfunction

  function automatic int lead_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : (k == 2) ? 2 : 7;
  endfunction

  logic        req_a, fs_a, de_a, hs_a, vs_a;
  logic [10:0] x_a;
  logic [9:0]  y_a;

  video_timing_gen #(.PIX_LEAD(2)) u_dut (
    .clk_pix(clk_pix), .srst_n(srst_n), .run(run_a), .pix_req(req_a), .pix_x(x_a),
    .pix_y(y_a), .frame_start(fs_a), .de(de_a), .hsync(hs_a), .vsync(vs_a)
  );

  logic        s_req[4], s_fs[4], s_de[4], s_hs[4], s_vs[4];
  logic [10:0] s_x[4];
  logic [9:0]  s_y[4];

  for (genvar k = 0; k < 4; k++) begin : g_small
    video_timing_gen #(
      .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
      .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(1),
      .PIX_LEAD((k == 0) ? 0 : (k == 1) ? 1 : (k == 2) ? 2 : 7)
    ) u_small (
      .clk_pix(clk_pix), .srst_n(srst_n), .run(run_s), .pix_req(s_req[k]), .pix_x(s_x[k]),
      .pix_y(s_y[k]), .frame_start(s_fs[k]), .de(s_de[k]), .hsync(s_hs[k]),
      .vsync(s_vs[k])
    );
  end

  initial begin
    logic [25:0] m_req, m_vid;
    int errs_a, cnt_line, cnt_hs, first_hs, line1_n, cnt_req_s, cnt_de_s, cnt_vs_s;
    int fs1, fs2;
    int errs_s[4];
    logic hs_prev;
    errs_a = 0; cnt_line = 0; cnt_hs = 0; first_hs = 0; line1_n = 0;
    cnt_req_s = 0; cnt_de_s = 0; cnt_vs_s = 0; fs1 = 0; fs2 = 0; hs_prev = 1'b0;
    for (int k = 0; k < 4; k++) errs_s[k] = 0;

    // Reset state
    #23;
    check("rst_req", 32'(req_a), 32'd0);
    check("rst_xy", 32'({x_a, y_a}), 32'd0);
    check("rst_fs", 32'(fs_a), 32'd0);
    check("rst_de", 32'(de_a), 32'd0);
    check("rst_hsync", 32'(hs_a), 32'd0);
    check("rst_vsync", 32'(vs_a), 32'd1);
    check("rst_small_l7", 32'({s_de[3], s_hs[3], s_vs[3]}), 32'd1);

    @(negedge clk_pix);
    srst_n = 1'b1; run_a = 1'b1; run_s = 1'b1;

    for (int n = 1; n <= 2800; n++) begin
      @(posedge clk_pix); #1;
      m_req = model(1'b1, n - 1);
      m_vid = model(1'b1, n - 3);
      if ({req_a, fs_a, x_a, y_a} !== m_req[25:3]) errs_a++;
      if ({de_a, hs_a, vs_a} !== m_vid[2:0]) errs_a++;
      if (n == 1) begin
        check("start_fs", 32'(fs_a), 32'd1);
        check("start_req", 32'(req_a), 32'd1);
        check("start_xy", 32'({x_a, y_a}), 32'd0);
      end
      if (n == 1 || n == 2) check($sformatf("start_de_low_e%0d", n), 32'(de_a), 32'd0);
      if (n == 3) check("start_de_rise_e3", 32'(de_a), 32'd1);
      if (n <= 1360 && req_a) cnt_line++;
      if (n <= 1362 && hs_a) cnt_hs++;
      if (hs_a && !hs_prev && first_hs == 0) first_hs = n;
      hs_prev = hs_a;
      if (req_a && x_a == 11'd0 && y_a == 10'd1 && line1_n == 0) line1_n = n;
      if (n <= 560) begin
        for (int k = 0; k < 4; k++) begin
          m_req = model(1'b0, n - 1);
          m_vid = model(1'b0, n - 1 - lead_of(k));
          if ({s_req[k], s_fs[k], s_x[k], s_y[k]} !== m_req[25:3]) errs_s[k]++;
          if ({s_de[k], s_hs[k], s_vs[k]} !== m_vid[2:0]) errs_s[k]++;
        end
        if (n <= 275 && s_req[2]) cnt_req_s++;
        if (n <= 277 && s_de[2]) cnt_de_s++;
        if (n <= 277 && !s_vs[2]) cnt_vs_s++;
        if (s_fs[2]) begin
          if (fs1 == 0) fs1 = n;
          else if (fs2 == 0) fs2 = n;
        end
      end
    end

    check("big_raster_model", 32'(errs_a), 32'd0);
    check("line_req_count", 32'(cnt_line), 32'd1280);
    check("line_hsync_width", 32'(cnt_hs), 32'd32);
    check("line_hsync_first_edge", 32'(first_hs), 32'd1291);
    check("line_period", 32'(line1_n - 1), 32'd1360);
    for (int k = 0; k < 4; k++)
      check($sformatf("align_lead%0d", lead_of(k)), 32'(errs_s[k]), 32'd0);
    check("frame_req_count", 32'(cnt_req_s), 32'd96);
    check("frame_de_count", 32'(cnt_de_s), 32'd96);
    check("frame_vsync_low", 32'(cnt_vs_s), 32'd50);
    check("frame_start_period", 32'(fs2 - fs1), 32'd275);

    // Asynchronous reset in mid-line, while de is high
    check("pre_rst_de", 32'(de_a), 32'd1);
    srst_n = 1'b0;
    run_s  = 1'b0;
    #1;
    check("async_rst_de", 32'(de_a), 32'd0);
    check("async_rst_syncs", 32'({hs_a, vs_a}), 32'd1);
    check("async_rst_req", 32'({req_a, fs_a}), 32'd0);
    check("async_rst_small_l7", 32'({s_de[3], s_hs[3], s_vs[3]}), 32'd1);
    @(negedge clk_pix);
    srst_n = 1'b1;
    for (int m = 1; m <= 3; m++) begin
      @(posedge clk_pix); #1;
      m_req = model(1'b1, m - 1);
      m_vid = model(1'b1, m - 3);
      check($sformatf("restart_req_e%0d", m), 32'({req_a, fs_a, x_a, y_a}), 32'(m_req[25:3]));
      check($sformatf("restart_vid_e%0d", m), 32'({de_a, hs_a, vs_a}), 32'(m_vid[2:0]));
    end

    // Drop run on the reduced raster at row 3, column 8, then raise it again
    @(negedge clk_pix);
    run_s = 1'b1;
    for (int n = 1; n <= 84; n++) begin
      @(posedge clk_pix); #1;
    end
    check("pre_drop_req", 32'({s_req[2], s_x[2], s_y[2]}), 32'({1'b1, 11'd8, 10'd3}));
    run_s = 1'b0;
    @(posedge clk_pix); #1;
    check("drop_req_idle", 32'({s_req[2], s_fs[2], s_x[2], s_y[2]}), 32'd0);
    check("drop_de_lead0", 32'(s_de[0]), 32'd0);
    @(posedge clk_pix); #1;
    check("drop_de_draining", 32'(s_de[2]), 32'd1);
    @(posedge clk_pix); #1;
    check("drop_de_drained", 32'(s_de[2]), 32'd0);
    @(negedge clk_pix);
    run_s = 1'b1;
    @(posedge clk_pix); #1;
    check("rerun_fs_origin", 32'({s_req[2], s_fs[2], s_x[2], s_y[2]}),
          32'({1'b1, 1'b1, 11'd0, 10'd0}));
    @(posedge clk_pix); #1;
    check("rerun_x1", 32'({s_fs[2], s_x[2]}), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Generates raster timing for the 1280x720@60Hz CVT-RBv2 HDMI path.
- Runs in the pixel clock domain (60.465MHz) and is released by the PLL block's synchronized reset.
- Produces a pixel-request stream (x/y coordinates, leading by PIX_LEAD cycles) for the frame-buffer/tile renderer.
- Produces the aligned de/hsync/vsync consumed by the TMDS encoder and serializer.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FRONT, 8, horizontal front porch (pixels)
- H_SYNC, 32, hsync width (pixels)
- H_BACK, 40, horizontal back porch (pixels)
- V_ACTIVE, 720, active lines per frame
- V_FRONT, 7, vertical front porch (lines)
- V_SYNC, 8, vsync width (lines)
- V_BACK, 6, vertical back porch (lines)
- HS_POL, 1'b1, hsync active level
- VS_POL, 1'b0, vsync active level
- PIX_LEAD, 2, cycles by which pix_req/pix_x/pix_y lead de; range 0..7

Ports:
- clk_pix, input, 1, pixel clock (60.465MHz)
- srst_n, input, 1, reset, asynchronous assert, active-low
- run, input, 1, enable; low holds the raster idle at origin
- pix_req, output, 1, pixel fetch request for (pix_x, pix_y)
- pix_x, output, 11, requested column, 0..H_ACTIVE-1
- pix_y, output, 10, requested row, 0..V_ACTIVE-1
- frame_start, output, 1, one-cycle pulse coincident with pix_req for (0,0)
- de, output, 1, data enable, PIX_LEAD cycles after the matching pix_req
- hsync, output, 1, horizontal sync, aligned with de
- vsync, output, 1, vertical sync, aligned with de

Behaviour:
- Clock and reset: one clock, clk_pix; reset is asynchronous and active-low, srst_n.
- Counters: hcnt 11b counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK = 1360. vcnt 10b counts 0..V_TOTAL-1, where V_TOTAL = 741.
- Wrap-around: hcnt wraps to 0 at H_TOTAL-1. vcnt increments only on hcnt wrap and wraps to 0 at V_TOTAL-1, in the same cycle as the hcnt wrap.
- Horizontal regions (by hcnt):
  - active 0..1279
  - front porch 1280..1287
  - sync 1288..1319
  - back porch 1320..1359
- Vertical regions (by vcnt):
  - active 0..719
  - front porch 720..726
  - sync 727..734
  - back porch 735..740
- vsync changes only at hcnt=0 boundaries.
- Request stage (registered, 1 cycle after counters):
  - pix_req = (hcnt<H_ACTIVE) && (vcnt<V_ACTIVE).
  - pix_x = hcnt and pix_y = vcnt when pix_req=1; both are 0 when pix_req=0.
  - frame_start = 1 only when hcnt=0 && vcnt=0.
- Video stage:
  - de/hsync/vsync are derived at the request stage, then delayed through a PIX_LEAD-deep register pipeline.
  - PIX_LEAD=0 means they are aligned with pix_req.
  - Inactive sync level = ~HS_POL / ~VS_POL.
- Reset (srst_n=0):
  - counters = 0
  - pix_req = 0, pix_x = 0, pix_y = 0, frame_start = 0
  - de = 0, hsync = ~HS_POL, vsync = ~VS_POL
  - all delay-pipeline stages hold the idle values above
- Start-up: first rising clk_pix edge with srst_n=1 and run=1 loads the request stage with pix_req=1, (0,0), frame_start=1. de first rises PIX_LEAD edges later.
- run=0 at any point, including mid-frame:
  - counters forced to 0 on the next edge.
  - request stage forced idle on that edge; delay pipeline keeps shifting, so video outputs drain to idle within PIX_LEAD cycles.
  - on run re-assertion, the raster restarts at (0,0) with frame_start.
- Reset mid-operation: all outputs go idle immediately (asynchronous); restart follows the start-up rule.
- Invariants:
  - no partial lines/frames other than those truncated by run/reset
  - exactly H_ACTIVE*V_ACTIVE = 921600 pix_req cycles per complete frame
- Synthesis-time rejection (elaboration error) when:
  - H_TOTAL>2047
  - V_TOTAL>1023
  - PIX_LEAD>7

Test Plan:
- Reset release, run=1, PIX_LEAD=2 -> frame_start and pix_req with (0,0) on edge 1; de rises on edge 3; hsync idle-low, vsync idle-high until sync regions.
- Single line -> pix_req high 1280 consecutive cycles with pix_x 0..1279; hsync high exactly 32 cycles starting 1288 cycles after line's first pix_req (+PIX_LEAD); line period 1360 cycles.
- Full frame -> 921600 pix_req cycles and 921600 de cycles; vsync low for 8*1360 = 10880 cycles starting at line 727; frame_start period 1,007,760 cycles (60.0Hz at 60.465MHz).
- Alignment sweep PIX_LEAD = 0, 1, 7 -> de/hsync/vsync equal the pix_req-stage values delayed exactly PIX_LEAD cycles, every cycle of one frame.
- run dropped at line 300, pixel 640 -> pix_req=0 next edge; de=0 within PIX_LEAD cycles; re-raise run -> frame_start with (0,0) next edge.
- srst_n asserted mid-line during de=1 -> de=0, hsync/vsync idle with no clock edge; after release, raster restarts at (0,0).
